// File: rtl/carregador_matriz_pkg.sv
// Shared ULA definitions: element/bus geometry, FSM state encoding and
// the row/column to flat-element index mapping used by the loader stages.
package carregador_matriz_pkg;

  localparam int ELEM_W  = 8;
  localparam int MAX_DIM = 5;
  localparam int N_ELEM  = MAX_DIM * MAX_DIM;
  localparam int MAT_W   = N_ELEM * ELEM_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ESCALAR = 2'd1;
  localparam logic [1:0] ST_CARGA   = 2'd2;
  localparam logic [1:0] ST_PRONTO  = 2'd3;

  // Flat element index on the 5x5 bus: lin*5 + col, in 5-bit arithmetic.
  function automatic logic [4:0] elem_index(input logic [2:0] lin, input logic [2:0] col);
    return ({2'b00, lin} * 5'd5) + {2'b00, col};
  endfunction

  // Dimensions the ULA can process.
  function automatic logic tamanho_ok(input logic [2:0] t);
    return (t >= 3'd2) && (t <= 3'd5);
  endfunction

endpackage

// File: rtl/carregador_matriz.sv
// Matrix loader: accepts an optional scalar plus an NxN row-major byte
// stream, packs it into the zero-padded 5x5 bus and holds it behind a
// valid/ack handshake until the ULA consumes it.
module carregador_matriz
  import carregador_matriz_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       tamanho,
  input  logic             com_escalar,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic [MAT_W-1:0] matriz_a,
  output logic [7:0]       data_escalar,
  output logic             matriz_valid,
  input  logic             matriz_ack,
  output logic             ocupado,
  output logic             erro
);

  logic [1:0]       state_q, state_d;
  logic [2:0]       lin_q, lin_d;
  logic [2:0]       col_q, col_d;
  logic [2:0]       n_q, n_d;
  logic [7:0]       esc_q, esc_d;
  logic             erro_q, erro_d;
  logic [MAT_W-1:0] matriz_q, matriz_d;
  logic             clr_s;
  logic             load_s;
  logic             xfer_s;
  logic [4:0]       idx_s;
  logic [N_ELEM-1:0] we_s;

  assign data_ready   = (state_q == ST_ESCALAR) || (state_q == ST_CARGA);
  assign matriz_valid = (state_q == ST_PRONTO);
  assign ocupado      = (state_q != ST_IDLE);
  assign erro         = erro_q;
  assign matriz_a     = matriz_q;
  assign data_escalar = esc_q;

  // data_ready is a pure state decode, so a transfer never loops back
  // combinationally into data_valid.
  assign xfer_s = data_valid & data_ready;
  assign idx_s  = elem_index(lin_q, col_q);

  // One byte-enable per bus element; unwritten elements keep their value
  // (zero after the clear at start), which gives the padding outside NxN.
  for (genvar g = 0; g < N_ELEM; g++) begin : g_elem
    assign we_s[g] = load_s && (idx_s == 5'(g));
    assign matriz_d[g*ELEM_W +: ELEM_W] = clr_s   ? {ELEM_W{1'b0}} :
                                          we_s[g] ? data_in :
                                                    matriz_q[g*ELEM_W +: ELEM_W];
  end

  // Next-state logic: FSM transitions, counters, scalar capture, error pulse.
  always_comb begin
    state_d = state_q;
    lin_d   = lin_q;
    col_d   = col_q;
    n_d     = n_q;
    esc_d   = esc_q;
    erro_d  = 1'b0;
    clr_s   = 1'b0;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (tamanho_ok(tamanho)) begin
            clr_s = 1'b1;
            lin_d = 3'd0;
            col_d = 3'd0;
            n_d   = tamanho;
            if (com_escalar) begin
              state_d = ST_ESCALAR;
            end else begin
              // No scalar streamed: the ULA multiplies by zero.
              esc_d   = 8'd0;
              state_d = ST_CARGA;
            end
          end else begin
            erro_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ESCALAR: begin
        if (xfer_s) begin
          esc_d   = data_in;
          state_d = ST_CARGA;
        end else begin
          state_d = ST_ESCALAR;
        end
      end
      ST_CARGA: begin
        if (xfer_s) begin
          load_s = 1'b1;
          if (col_q == (n_q - 3'd1)) begin
            col_d = 3'd0;
            lin_d = lin_q + 3'd1;
            if (lin_q == (n_q - 3'd1)) begin
              state_d = ST_PRONTO;
            end else begin
              state_d = ST_CARGA;
            end
          end else begin
            col_d = col_q + 3'd1;
          end
        end else begin
          state_d = ST_CARGA;
        end
      end
      ST_PRONTO: begin
        // Ack wins over any start seen in the same cycle; start is only
        // looked at in IDLE.
        if (matriz_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_PRONTO;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset discarding any partial load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      lin_q    <= 3'd0;
      col_q    <= 3'd0;
      n_q      <= 3'd0;
      esc_q    <= 8'd0;
      erro_q   <= 1'b0;
      matriz_q <= {MAT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      lin_q    <= lin_d;
      col_q    <= col_d;
      n_q      <= n_d;
      esc_q    <= esc_d;
      erro_q   <= erro_d;
      matriz_q <= matriz_d;
    end
  end

endmodule

// File: doc/carregador_matriz.md
# carregador_matriz

Input-assembly stage directly upstream of the ULA scalar-multiply unit. Accepts a byte stream (optional scalar followed by an N×N matrix in row-major order) over a valid/ready handshake. Packs it into the 200-bit 5×5 matrix bus with zero padding outside the N×N region, then holds matrix plus scalar stable behind a valid/ack handshake until the ULA consumes them.

## Interface
- ELEM_W, 8 — element width in bits (fixed; the ULA bus assumes 8).
- MAX_DIM, 5 — maximum matrix dimension; bus width = MAX_DIM²·ELEM_W = 200.

Ports:
- clk  in  1  — single clock, all state on rising edge.
- reset  in  1  — asynchronous, active-high; clears all state and outputs.
- start  in  1  — load-request pulse; sampled only in IDLE.
- tamanho  in  3  — matrix dimension N, sampled with start; valid range 2..5.
- com_escalar  in  1  — sampled with start; 1 = first streamed byte is the scalar.
- data_in  in  8  — streamed byte.
- data_valid  in  1  — data_in valid.
- data_ready  out  1  — block accepts a byte this cycle.
- matriz_a  out  200  — packed matrix; element (r,c) at bits [(r·5+c)·8 +: 8].
- data_escalar  out  8  — scalar.
- matriz_valid  out  1  — matriz_a/data_escalar complete and stable.
- matriz_ack  in  1  — consumer took the data.
- ocupado  out  1  — high in any state except IDLE.
- erro  out  1  — one-cycle pulse on rejected start.

## Operation
- FSM states: IDLE, ESCALAR, CARGA, PRONTO. Registered state; outputs decoded from registers.
- IDLE with start=1:
  - tamanho in 2..5: matriz_a cleared to 0, row/col counters cleared. Go to ESCALAR if com_escalar=1, else CARGA.
  - data_escalar cleared to 0 only when com_escalar=0. Without a scalar the ULA multiplies by 0; callers wanting identity must stream 1.
  - tamanho in {0,1,6,7}: erro=1 for one cycle, stay IDLE, no register changes.
- Transfer = data_valid & data_ready. data_ready=1 exactly in ESCALAR and CARGA; no combinational path from data_valid.
- ESCALAR: on transfer, data_escalar←data_in, go to CARGA.
- CARGA: on transfer, write data_in at index lin·5+col, then advance col. Wrap col to 0 and increment lin when col=N−1. Elements with lin≥N or col≥N stay 0.
- Leave CARGA when the transfer is element (N−1,N−1); go to PRONTO.
- PRONTO: matriz_valid=1; matriz_a/data_escalar held. matriz_ack=1 → IDLE. Outputs keep their values after ack until the next accepted start.
- start outside IDLE ignored (no erro). matriz_ack outside PRONTO ignored. data_valid outside ESCALAR/CARGA ignored, byte dropped.
- Counters 3-bit; index computed as lin·5+col (max 24) via 5-bit arithmetic.

## Timing
- Reset values: matriz_a=0, data_escalar=0, matriz_valid=0, data_ready=0, ocupado=0, erro=0, state IDLE, counters 0.
- Reset asserted mid-load or in PRONTO: immediate return to all reset values; partial matrix discarded.
- start at edge k → data_ready=1 from cycle k+1.
- Full-rate streaming: last transfer at edge j → matriz_valid=1 from cycle j+1.
- Total latency from start with no stalls: 1 + N² (+1 if com_escalar) cycles until matriz_valid.
- Stalls (data_valid=0) hold state and counters.
- matriz_ack at edge m → matriz_valid=0, ocupado=0 in cycle m+1. A new start may be accepted at edge m+1.
- Same-cycle start and ack in PRONTO: ack honoured, start ignored.

## Structure
- Shared ULA package: ELEM_W, MAX_DIM, MAT_W=200, and the state encoding (IDLE=0, ESCALAR=1, CARGA=2, PRONTO=3) for reuse by the result-writer stage.
- Single flat module; no sub-module. The element write is a generate-loop of 25 byte-enables decoded from the index.

## Test plan
- N=2, com_escalar=1, stream 3,1,2,3,4 → data_escalar=3; bytes 0,1,5,6 = 1,2,3,4; all others 0; matriz_valid 6 cycles after start.
- N=5, com_escalar=0, stream 1..25 → byte i = i+1, data_escalar=0, matriz_valid 26 cycles after start.
- N=3 with data_valid toggling 1/0 every cycle → same packing as no-stall run (index 0,1,2,5,6,7,10,11,12), valid delayed by stall count.
- tamanho=6 start → erro one-cycle pulse, ocupado stays 0, matriz_a unchanged; tamanho=1 likewise.
- Reset asserted after 7 of 16 bytes (N=4) → all outputs 0 next cycle; new N=2 load completes correctly.
- In PRONTO, hold ack low 10 cycles with start pulses → matriz_a stable, valid held; ack → IDLE next cycle, outputs retained.
